// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port SRAM block with a registered
// read output. Port 0 (display scan-out) has default priority; port 1 (image
// update) is guaranteed service after MAX_WAIT consecutive denied cycles.
module sram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  // port 0: read-only
  input  logic                  r0_req,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  // port 1: read/write
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  // SRAM side
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_wdata,
  input  logic [DATA_WIDTH-1:0] sram_rdata
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  // Owner of the read data arriving from the SRAM in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  logic [3:0] wait_cnt_q, wait_cnt_d;
  owner_e     rd_owner_q, rd_owner_d;
  logic       force_p1;

  // Grant decision: port 1 wins only when port 0 is idle or port 1 has
  // starved for MAX_WAIT cycles; reset masks both grants immediately.
  always_comb begin
    force_p1 = r1_req && (wait_cnt_q == MAX_WAIT_C);
    r1_gnt   = reset_n && r1_req && (force_p1 || !r0_req);
    r0_gnt   = reset_n && r0_req && !r1_gnt;
  end

  // SRAM command mux driven by whichever port holds the grant.
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (r0_gnt) begin
      sram_en   = 1'b1;
      sram_addr = r0_addr;
    end else if (r1_gnt) begin
      sram_en    = 1'b1;
      sram_we    = r1_we;
      sram_addr  = r1_addr;
      sram_wdata = r1_wdata;
    end
  end

  // Next-state for the starvation counter and the read-data owner.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!r1_req || r1_gnt) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q < MAX_WAIT_C) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end

    rd_owner_d = OWN_NONE;
    if (r0_gnt) begin
      rd_owner_d = OWN_P0;
    end else if (r1_gnt && !r1_we) begin
      rd_owner_d = OWN_P1;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
      rd_owner_q <= OWN_NONE;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // rvalid is gated by reset so a read in flight when reset asserts is dropped.
  always_comb begin
    r0_rvalid = reset_n && (rd_owner_q == OWN_P0);
    r1_rvalid = reset_n && (rd_owner_q == OWN_P1);
    r0_rdata  = sram_rdata;
    r1_rdata  = sram_rdata;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: SRAM word width.
REQ-002 Parameter ADDR_WIDTH, default 16: SRAM address width.
REQ-003 Parameter MAX_WAIT, default 4, range 1..15: consecutive denied cycles of port 1 before it is forced to win.
REQ-004 Port clk  in  1: the only clock; all state updates on its rising edge.
REQ-005 Port reset_n  in  1: reset, synchronous and active-low.
REQ-006 Port r0_req  in  1: port 0 (display scan-out) read request, held until granted.
REQ-007 Port r0_addr  in  ADDR_WIDTH: port 0 read address.
REQ-008 Port r0_gnt  out  1: port 0 request accepted this cycle.
REQ-009 Port r0_rvalid  out  1: r0_rdata valid this cycle.
REQ-010 Port r0_rdata  out  DATA_WIDTH: port 0 read data.
REQ-011 Port r1_req  in  1: port 1 (image update) request, held until granted.
REQ-012 Port r1_we  in  1: port 1 write when 1, read when 0.
REQ-013 Port r1_addr  in  ADDR_WIDTH: port 1 address.
REQ-014 Port r1_wdata  in  DATA_WIDTH: port 1 write data.
REQ-015 Port r1_gnt  out  1: port 1 request accepted this cycle.
REQ-016 Port r1_rvalid  out  1: r1_rdata valid this cycle (reads only).
REQ-017 Port r1_rdata  out  DATA_WIDTH: port 1 read data.
REQ-018 Ports sram_en, sram_we  out  1, sram_addr  out  ADDR_WIDTH, sram_wdata  out  DATA_WIDTH: drive the SRAM block.
REQ-019 Port sram_rdata  in  DATA_WIDTH: SRAM registered output, valid one cycle after an enabled access.

Function
REQ-020 Grants shall be combinational in the request cycle; a transfer occurs on any cycle with rX_req and rX_gnt both high.
REQ-021 At most one of r0_gnt, r1_gnt shall be high in any cycle.
REQ-022 Default priority: port 0 wins when both request.
REQ-023 Register wait_cnt (4 bits): +1 each cycle with r1_req=1 and r1_gnt=0; cleared on r1 grant or r1_req=0; saturates at MAX_WAIT.
REQ-024 When wait_cnt == MAX_WAIT and r1_req=1, port 1 shall win over port 0 that cycle.
REQ-025 Grant to port 0: sram_en=1, sram_we=0, sram_addr=r0_addr.
REQ-026 Grant to port 1: sram_en=1, sram_we=r1_we, sram_addr=r1_addr, sram_wdata=r1_wdata.
REQ-027 No grant: sram_en=0, sram_we=0, sram_addr and sram_wdata 0.
REQ-028 Register rd_owner, states NONE/P0/P1: set to P0 on port 0 grant, P1 on port 1 read grant, NONE otherwise (including port 1 writes).
REQ-029 r0_rvalid = (rd_owner==P0), r1_rvalid = (rd_owner==P1); read latency exactly 1 cycle after grant.
REQ-030 r0_rdata and r1_rdata shall both pass sram_rdata through; only the matching rvalid qualifies it.
REQ-031 Back-to-back grants every cycle shall be sustained with no bubble; alternating owners shall give correct rvalid per cycle.
REQ-032 Write to an address followed by a port 1 read of it in the next cycle shall return the new data.

Reset
REQ-033 While reset_n=0: r0_gnt, r1_gnt, sram_en, sram_we forced 0 combinationally; at the clock edge wait_cnt=0, rd_owner=NONE.
REQ-034 Outputs after reset: all grants 0, both rvalid 0, sram_addr/sram_wdata 0.
REQ-035 Reset asserted in the cycle after a read grant shall suppress that read's rvalid; no transfer completes during reset.

Verification
REQ-036 r0 read 0x0010 alone, SRAM holds 0x3C -> r0_gnt same cycle, next cycle r0_rvalid=1, r0_rdata=0x3C, r1_rvalid=0.
REQ-037 r0 and r1 request continuously, MAX_WAIT=4 -> r0 granted cycles 1-4, r1 granted cycle 5, wait_cnt back to 0, r0 granted cycle 6.
REQ-038 r1 write 0x1234<-0xA5, then r1 read 0x1234 -> no rvalid after write; r1_rvalid=1, r1_rdata=0xA5 one cycle after read grant.
REQ-039 r1 waits 2 cycles then drops r1_req -> wait_cnt=0; new r1 request with r0 busy needs 4 more denied cycles.
REQ-040 reset_n low in cycle after r0 read grant -> r0_rvalid=0, no grants while low; first request after release granted normally.
REQ-041 No requests for 10 cycles -> sram_en=0, both gnt and rvalid 0 throughout.
